// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the image_ram port arbiter
// Purpose: arbiter FSM state, read-return tag layout and image_ram geometry.
// Ports: none (package).
package mem_arb_pkg;

  localparam int IMG_AW    = 14;
  localparam int IMG_DW    = 8;
  localparam int IMG_DEPTH = 16384;

  // Wide enough to tag up to 16 requesters.
  localparam int TAG_ID_W  = 4;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    HALTED
  } arb_state_t;

  typedef struct packed {
    logic                vld;
    logic [TAG_ID_W-1:0] id;
  } rd_tag_t;

endpackage

// File: rtl/mem_port_arbiter_rr_picker.sv
// rtl/mem_port_arbiter_rr_picker.sv - N-way round-robin priority picker
// Purpose: grants the first unmasked request at or after ptr (wrapping) and reports
//   the pointer position just past the winner.
// Ports:
//   req      in   N   request vector
//   mask     in   N   1 = entry may not win this cycle
//   ptr      in   PW  highest-priority entry
//   gnt      out  N   one-hot grant (zero when nothing eligible)
//   next_ptr out  PW  winner+1 (wrapping), or ptr when no grant
module rr_picker #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  mask,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] next_ptr
);

  always_comb begin
    int   idx;
    logic found;
    gnt      = '0;
    next_ptr = ptr;
    found    = 1'b0;
    idx      = 0;
    for (int i = 0; i < N; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N) idx = idx - N;
      for (int j = 0; j < N; j++) begin
        if (!found && (j == idx) && req[j] && !mask[j]) begin
          gnt[j]   = 1'b1;
          found    = 1'b1;
          next_ptr = (j == N - 1) ? '0 : PW'(j + 1);
        end
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares single-port image_ram among a host loader and compute readers
// Purpose: one grant per cycle (host first, bounded by HOST_MAX while readers wait, readers
//   round-robin), registered RAM issue, tagged read return, halt/drain handshake.
// Optional feature: MEM_ARB_STATS_EN adds stat_clr/stat_grants saturating grant counters.
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   req_valid/ready/we        per-requester handshake and direction (index 0 = host)
//   req_addr/req_wdata        packed per-requester address / write data
//   rsp_valid/rsp_data        per-requester read return strobe, shared data
//   halt_req/halted           quiesce request / RAM idle indication
//   ram_addr/ram_data/ram_wren/ram_q  image_ram interface
//   stat_clr/stat_grants      (MEM_ARB_STATS_EN only) counter clear / packed 16-bit counters
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N_REQ    = 3,
  parameter int AW       = IMG_AW,
  parameter int DW       = IMG_DW,
  parameter int RD_LAT   = 2,
  parameter int HOST_MAX = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [N_REQ-1:0]    req_valid,
  output logic [N_REQ-1:0]    req_ready,
  input  logic [N_REQ-1:0]    req_we,
  input  logic [N_REQ*AW-1:0] req_addr,
  input  logic [N_REQ*DW-1:0] req_wdata,
  output logic [N_REQ-1:0]    rsp_valid,
  output logic [DW-1:0]       rsp_data,
  input  logic                halt_req,
  output logic                halted,
`ifdef MEM_ARB_STATS_EN
  input  logic                stat_clr,
  output logic [N_REQ*16-1:0] stat_grants,
`endif
  output logic [AW-1:0]       ram_addr,
  output logic [DW-1:0]       ram_data,
  output logic                ram_wren,
  input  logic [DW-1:0]       ram_q
);

  localparam int NR     = N_REQ - 1;
  localparam int PW     = (NR > 1) ? $clog2(NR) : 1;
  localparam int HC_W   = $clog2(HOST_MAX + 1);
  localparam int PIPE_D = 1 + RD_LAT;

  arb_state_t          state, state_nxt;
  // Pointer is in reader space: 0 means requester 1.
  logic [PW-1:0]       rr_ptr, rr_ptr_nxt;
  logic [HC_W-1:0]     host_cnt;
  rd_tag_t             tag_pipe [PIPE_D];
  logic                grant_ok, host_mask, host_win, pipe_busy;
  logic [NR-1:0]       rd_gnt;
  logic [AW-1:0]       sel_addr;
  logic [DW-1:0]       sel_wdata;
  logic                sel_we;
  logic [TAG_ID_W-1:0] sel_id;

  // Host yields for one cycle once it has used its burst allowance and a reader waits.
  assign host_mask = (host_cnt == HC_W'(HOST_MAX)) && (|req_valid[N_REQ-1:1]);
  assign host_win  = grant_ok && req_valid[0] && !host_mask;

  rr_picker #(.N(NR), .PW(PW)) u_rr_picker (
    .req      (req_valid[N_REQ-1:1]),
    .mask     ({NR{!grant_ok || host_win}}),
    .ptr      (rr_ptr),
    .gnt      (rd_gnt),
    .next_ptr (rr_ptr_nxt)
  );

  assign req_ready = {rd_gnt, host_win};

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_we    = 1'b0;
    sel_id    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (req_ready[i]) begin
        sel_addr  = req_addr[i*AW +: AW];
        sel_wdata = req_wdata[i*DW +: DW];
        sel_we    = req_we[i];
        sel_id    = TAG_ID_W'(i);
      end
    end
  end

  always_comb begin
    pipe_busy = 1'b0;
    for (int i = 0; i < PIPE_D; i++) pipe_busy = pipe_busy | tag_pipe[i].vld;
  end

  // halt_req blocks grants in the very cycle it is seen.
  always_comb begin
    state_nxt = state;
    grant_ok  = 1'b0;
    halted    = 1'b0;
    unique case (state)
      RUN: begin
        grant_ok = !halt_req;
        if (halt_req) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (!halt_req)      state_nxt = RUN;
        else if (!pipe_busy) state_nxt = HALTED;
      end
      HALTED: begin
        halted = 1'b1;
        if (!halt_req) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= RUN;
      rr_ptr   <= '0;
      host_cnt <= '0;
      ram_addr <= '0;
      ram_data <= '0;
      ram_wren <= 1'b0;
      for (int i = 0; i < PIPE_D; i++) tag_pipe[i] <= '0;
    end else begin
      state <= state_nxt;
      if (|rd_gnt) rr_ptr <= rr_ptr_nxt;
      if (host_win) begin
        if (host_cnt != HC_W'(HOST_MAX)) host_cnt <= host_cnt + HC_W'(1);
      end else begin
        host_cnt <= '0;
      end
      ram_wren <= 1'b0;
      if (|req_ready) begin
        ram_addr <= sel_addr;
        ram_data <= sel_wdata;
        ram_wren <= sel_we;
      end
      tag_pipe[0] <= '{vld: (|req_ready) && !sel_we, id: sel_id};
      for (int i = 1; i < PIPE_D; i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  // Last tag stage lines up with ram_q for the same access.
  always_comb begin
    rsp_valid = '0;
    rsp_data  = '0;
    if (tag_pipe[PIPE_D-1].vld) begin
      rsp_data = ram_q;
      for (int i = 0; i < N_REQ; i++)
        if (tag_pipe[PIPE_D-1].id == TAG_ID_W'(i)) rsp_valid[i] = 1'b1;
    end
  end

`ifdef MEM_ARB_STATS_EN
  for (genvar g = 0; g < N_REQ; g++) begin : g_stat
    logic [15:0] cnt;
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                             cnt <= '0;
      else if (stat_clr)                        cnt <= '0;
      else if (req_ready[g] && cnt != 16'hFFFF) cnt <= cnt + 16'd1;
    end
    assign stat_grants[g*16 +: 16] = cnt;
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int AW = 14;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [2:0]      req_valid, req_ready, req_we, rsp_valid;
  logic [AW-1:0]   a0, a1, a2;
  logic [7:0]      d0;
  logic [3*AW-1:0] req_addr;
  logic [23:0]     req_wdata;
  logic [7:0]      rsp_data, ram_data, ram_q, q1;
  logic            halt_req, halted, ram_wren;
  logic [AW-1:0]   ram_addr;
`ifdef MEM_ARB_STATS_EN
  logic            stat_clr;
  logic [47:0]     stat_grants;
`endif

  assign req_addr  = {a2, a1, a0};
  assign req_wdata = {16'h0, d0};

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .halt_req  (halt_req),
    .halted    (halted),
`ifdef MEM_ARB_STATS_EN
    .stat_clr  (stat_clr),
    .stat_grants(stat_grants),
`endif
    .ram_addr  (ram_addr),
    .ram_data  (ram_data),
    .ram_wren  (ram_wren),
    .ram_q     (ram_q)
  );

  // image_ram model: two-cycle read latency from ram_addr, read-before-write.
  logic [7:0] ram [16384];
  always @(posedge clk) begin
    q1    <= ram[ram_addr];
    ram_q <= q1;
    if (ram_wren) ram[ram_addr] = ram_data;
  end

  int         checks, passes, cyc;
  logic [2:0] exp_rv [256];
  logic [7:0] exp_rd [256];
  logic [7:0] ref_mem [16384];
  logic          e_wren;
  logic [AW-1:0] e_addr;
  logic [7:0]    e_data;

  function automatic logic [7:0] f(input int a);
    return 8'(a * 3 + 17);
  endfunction

  task automatic chk(input string tag, input string what, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s.%s observed=%0h expected=%0h", tag, what, obs, exp);
  endtask

  // Checks one cycle at the negedge, then updates the expected RAM/response model
  // from the grant this cycle is expected to make.
  task automatic step(input logic [2:0] er, input logic eh, input string tag);
    logic [AW-1:0] ga;
    logic [7:0]    gd;
    logic          gw;
    @(negedge clk);
    chk(tag, "req_ready", 64'(req_ready), 64'(er));
    chk(tag, "halted", 64'(halted), 64'(eh));
    chk(tag, "rsp_valid", 64'(rsp_valid), 64'(exp_rv[cyc]));
    if (exp_rv[cyc] != 3'b000) chk(tag, "rsp_data", 64'(rsp_data), 64'(exp_rd[cyc]));
    chk(tag, "ram_wren", 64'(ram_wren), 64'(e_wren));
    chk(tag, "ram_addr", 64'(ram_addr), 64'(e_addr));
    if (e_wren) chk(tag, "ram_data", 64'(ram_data), 64'(e_data));
    e_wren = 1'b0;
    if (er != 3'b000) begin
      ga = er[0] ? a0 : (er[1] ? a1 : a2);
      gd = er[0] ? d0 : 8'h00;
      gw = er[0] ? req_we[0] : (er[1] ? req_we[1] : req_we[2]);
      e_addr = ga;
      e_data = gd;
      if (gw) begin
        e_wren = 1'b1;
        ref_mem[ga] = gd;
      end else begin
        exp_rv[cyc+3] = er;
        exp_rd[cyc+3] = ref_mem[ga];
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    req_valid = 3'b000;
    req_we    = 3'b000;
    halt_req  = 1'b0;
    e_wren    = 1'b0;
    e_addr    = '0;
    e_data    = '0;
    for (int i = 0; i < 256; i++) exp_rv[i] = 3'b000;
    @(negedge clk);
    chk("rst", "rsp_data", 64'(rsp_data), 64'h0);
    chk("rst", "ram_data", 64'(ram_data), 64'h0);
`ifdef MEM_ARB_STATS_EN
    chk("rst", "stat_grants", 64'(stat_grants), 64'h0);
`endif
    @(posedge clk);
    #1;
    cyc++;
    step(3'b000, 1'b0, "rst_hold");
    reset_n = 1'b1;
  endtask

  initial begin
    checks = 0; passes = 0; cyc = 0;
    reset_n = 1'b0; req_valid = '0; req_we = '0; halt_req = 1'b0;
    a0 = '0; a1 = '0; a2 = '0; d0 = '0;
`ifdef MEM_ARB_STATS_EN
    stat_clr = 1'b0;
`endif
    for (int i = 0; i < 16384; i++) begin
      ram[i]     = f(i);
      ref_mem[i] = f(i);
    end
    for (int i = 0; i < 256; i++) exp_rd[i] = 8'h00;
    @(posedge clk);
    #1;
    do_reset();

    // Host alone: back-to-back writes, no responses.
    req_valid = 3'b001; req_we = 3'b001;
    for (int i = 0; i < 4; i++) begin
      a0 = AW'(i);
      d0 = 8'hA0 + 8'(i);
      step(3'b001, 1'b0, "host_wr");
    end
    req_valid = 3'b000; req_we = 3'b000;
    step(3'b000, 1'b0, "wr_tail");
    step(3'b000, 1'b0, "wr_idle");

    // Two readers alternate.
    req_valid = 3'b110; a1 = 14'd5; a2 = 14'd9;
    step(3'b010, 1'b0, "rr0");
    step(3'b100, 1'b0, "rr1");
    step(3'b010, 1'b0, "rr2");
    step(3'b100, 1'b0, "rr3");
    req_valid = 3'b000;
    repeat (4) step(3'b000, 1'b0, "rr_drain");

    // Host burst limit against reader 1.
    req_valid = 3'b011; a0 = 14'd20; a1 = 14'd21;
    for (int i = 0; i < 20; i++)
      step((i == 8 || i == 17) ? 3'b010 : 3'b001, 1'b0, "starve");
    req_valid = 3'b000;
    repeat (4) step(3'b000, 1'b0, "starve_drain");

    // Halt with three reads in flight.
    req_valid = 3'b010; a1 = 14'd30;
    repeat (3) step(3'b010, 1'b0, "pre_halt");
    halt_req = 1'b1;
    repeat (4) step(3'b000, 1'b0, "draining");
    repeat (2) step(3'b000, 1'b1, "halted");
    halt_req = 1'b0;
    step(3'b000, 1'b1, "unhalt");
    step(3'b010, 1'b0, "resume");
    req_valid = 3'b000;
    repeat (4) step(3'b000, 1'b0, "resume_drain");

    // Write then read same address next cycle.
    req_valid = 3'b001; req_we = 3'b001; a0 = 14'd100; d0 = 8'h5A;
    step(3'b001, 1'b0, "raw_wr");
    req_valid = 3'b010; req_we = 3'b000; a1 = 14'd100;
    step(3'b010, 1'b0, "raw_rd");
    req_valid = 3'b000;
    step(3'b000, 1'b0, "raw_w1");
    step(3'b000, 1'b0, "raw_w2");
    @(negedge clk);
    chk("raw", "rsp_valid_lit", 64'(rsp_valid), 64'h2);
    chk("raw", "rsp_data_lit", 64'(rsp_data), 64'h5A);
    @(posedge clk);
    #1;
    cyc++;
    step(3'b000, 1'b0, "raw_idle");

    // Reset with two reads in flight.
    req_valid = 3'b110; a1 = 14'd40; a2 = 14'd41;
    step(3'b100, 1'b0, "pre_rst0");
    step(3'b010, 1'b0, "pre_rst1");
    do_reset();
    repeat (4) step(3'b000, 1'b0, "post_rst");
    req_valid = 3'b110;
    step(3'b010, 1'b0, "ptr_rst0");
    step(3'b100, 1'b0, "ptr_rst1");
    req_valid = 3'b000;
    repeat (4) step(3'b000, 1'b0, "final_drain");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
